// File: rtl/sequence_decode.sv
// Modified-Miller slot decoder: PCD pause falling edges -> X/Y/Z/ERROR strobe per bit slot.
// Strobe is DECIDE+1 cycles after a Z edge, TOL+2 after an X edge; there is no backpressure, one strobe per slot.
package sequence_decode_pkg;
  typedef enum logic [1:0] {
    PCDBitSequence_X     = 2'd0,
    PCDBitSequence_Y     = 2'd1,
    PCDBitSequence_Z     = 2'd2,
    PCDBitSequence_ERROR = 2'd3
  } PCDBitSequence;
endpackage

module sequence_decode
  import sequence_decode_pkg::*;
#(
  parameter int BIT_TICKS = 128,
  parameter int TOL       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pause_n_synchronised,
  output PCDBitSequence sd_seq,
  output logic          sd_seq_valid,
  output logic          idle
);

  localparam int PW = $clog2(BIT_TICKS);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_TICKS - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(BIT_TICKS / 2);
  localparam logic [PW-1:0] PH_DEC  = PW'(BIT_TICKS / 2 + TOL + 1);
  localparam logic [PW-1:0] PH_Z_LO = PW'(BIT_TICKS - TOL);
  localparam logic [PW-1:0] PH_Z_HI = PW'(TOL);
  localparam logic [PW-1:0] PH_X_LO = PW'(BIT_TICKS / 2 - TOL);
  localparam logic [PW-1:0] PH_X_HI = PW'(BIT_TICKS / 2 + TOL);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ph, w_ph_nxt;
  logic          r_pend_vld, w_pend_vld_nxt;
  PCDBitSequence r_pend, w_pend_nxt;
  logic          r_y_seen, w_y_seen_nxt;
  logic          r_pause_prev;
  PCDBitSequence w_seq_nxt;
  logic          w_seq_vld_nxt;
  logic          w_fall, w_in_z, w_in_x, w_decide;
  PCDBitSequence w_cls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ph         <= '0;
      r_pend_vld   <= 1'b0;
      r_pend       <= PCDBitSequence_Y;
      r_y_seen     <= 1'b0;
      r_pause_prev <= 1'b1;
      sd_seq       <= PCDBitSequence_Y;
      sd_seq_valid <= 1'b0;
      idle         <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_ph         <= w_ph_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_pend       <= w_pend_nxt;
      r_y_seen     <= w_y_seen_nxt;
      r_pause_prev <= pause_n_synchronised;
      sd_seq       <= w_seq_nxt;
      sd_seq_valid <= w_seq_vld_nxt;
      idle         <= (r_state == S_IDLE);
    end
  end

  always_comb begin
    w_fall   = r_pause_prev & ~pause_n_synchronised;
    w_in_z   = (r_ph >= PH_Z_LO) || (r_ph <= PH_Z_HI);
    w_in_x   = (r_ph >= PH_X_LO) && (r_ph <= PH_X_HI);
    w_decide = (r_ph == PH_DEC);
    w_cls    = w_in_z ? PCDBitSequence_Z : (w_in_x ? PCDBitSequence_X : PCDBitSequence_ERROR);

    w_state_nxt    = r_state;
    w_ph_nxt       = r_ph;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_nxt     = r_pend;
    w_y_seen_nxt   = r_y_seen;
    w_seq_nxt      = sd_seq;
    w_seq_vld_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ph_nxt = '0;
        if (w_fall) begin
          w_state_nxt    = S_ACTIVE;
          w_pend_vld_nxt = 1'b1;
          w_pend_nxt     = PCDBitSequence_Z;
          w_y_seen_nxt   = 1'b0;
        end
      end
      default: begin
        w_ph_nxt = (r_ph == PH_LAST) ? '0 : r_ph + PW'(1);
        if (w_decide) begin
          w_seq_vld_nxt  = 1'b1;
          w_seq_nxt      = r_pend_vld ? r_pend : PCDBitSequence_Y;
          w_pend_vld_nxt = 1'b0;
          w_y_seen_nxt   = !r_pend_vld;
          if (!r_pend_vld && r_y_seen) begin
            w_state_nxt  = S_IDLE;
            w_ph_nxt     = '0;
            w_y_seen_nxt = 1'b0;
          end
        end
        // An edge on the decide cycle belongs to the next slot, so the old pending value is ignored.
        if (w_fall && (w_state_nxt == S_ACTIVE)) begin
          w_pend_vld_nxt = 1'b1;
          w_pend_nxt     = (r_pend_vld && !w_decide) ? PCDBitSequence_ERROR : w_cls;
          if (w_in_z) begin
            w_ph_nxt = '0;
          end else if (w_in_x) begin
            w_ph_nxt = PH_HALF;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_decode.sv
// Bench for sequence_decode: pause-edge schedules against a timeline reference model.
module tb_sequence_decode;
  import sequence_decode_pkg::*;

  localparam int BT     = 128;
  localparam int TOL    = 8;
  localparam int HALF   = BT / 2;
  localparam int DECIDE = BT / 2 + TOL + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pause_n;
  PCDBitSequence sd_seq;
  logic          sd_seq_valid;
  logic          idle;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;
  int got_t[$];
  PCDBitSequence got_v[$];
  int idle_rise = -1;
  int idle_fall = -1;
  logic idle_q = 1'b1;

  sequence_decode #(.BIT_TICKS(BT), .TOL(TOL)) dut (
    .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n),
    .sd_seq(sd_seq), .sd_seq_valid(sd_seq_valid), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (sd_seq_valid) begin
      got_t.push_back(edge_n);
      got_v.push_back(sd_seq);
    end
    if (idle && !idle_q) idle_rise = edge_n;
    if (!idle && idle_q) idle_fall = edge_n;
    idle_q = idle;
  end

  // Timeline model: the slot grid is an absolute origin (edge where the phase is 0);
  // decide points sit at origin+DECIDE+k*BT and each accepted edge moves the origin.
  function automatic void model(input int fl[$], output int et[$], output PCDBitSequence ev[$],
                                output int idle_at);
    bit act = 0, has = 0;
    int base = 0, cur = 0, idx = 0, yc = 0, d, nf, p;
    PCDBitSequence pend = PCDBitSequence_Y, cls, v;
    et = {}; ev = {}; idle_at = -1;
    for (int g = 0; g < 2000; g++) begin
      if (!act) begin
        if (idx >= fl.size()) break;
        base = fl[idx] + 1; cur = base; pend = PCDBitSequence_Z; has = 1; yc = 0; act = 1; idx++;
      end else begin
        d = base + DECIDE;
        while (d < cur) d += BT;
        nf = (idx < fl.size()) ? fl[idx] : 32'h7fff_ffff;
        if (nf < d) begin
          p = (nf - base) % BT;
          if (p >= BT - TOL || p <= TOL) cls = PCDBitSequence_Z;
          else if (p >= HALF - TOL && p <= HALF + TOL) cls = PCDBitSequence_X;
          else cls = PCDBitSequence_ERROR;
          pend = has ? PCDBitSequence_ERROR : cls;
          has = 1;
          if (cls == PCDBitSequence_Z) base = nf + 1;
          else if (cls == PCDBitSequence_X) base = nf + 1 - HALF;
          cur = nf + 1; idx++;
        end else begin
          v = has ? pend : PCDBitSequence_Y;
          et.push_back(d); ev.push_back(v); has = 0; cur = d + 1;
          if (v == PCDBitSequence_Y) begin
            yc++;
            if (yc == 2) begin
              act = 0; idle_at = d + 1;
              while (idx < fl.size() && fl[idx] <= d) idx++;
            end
          end else yc = 0;
        end
      end
    end
  endfunction

  // Builds fall times from slot types; nom tracks where a nominal Z edge of the current slot lands.
  function automatic void gen(input PCDBitSequence typ[$], input int t0, input bit jit, input int mis,
                              input int mis_off, input int dbl, output int fl[$], output int wl[$]);
    int nom, f, j;
    fl = {}; wl = {}; nom = t0;
    foreach (typ[i]) begin
      if (i > 0) nom += BT;
      j = (jit && i > 0) ? int'($urandom_range(15)) - 7 : 0;
      if (i == mis) fl.push_back(nom + mis_off);
      else if (i == dbl) begin
        fl.push_back(nom + 1); fl.push_back(nom + 2 + HALF); nom = nom + 2;
      end else if (typ[i] == PCDBitSequence_Z) begin
        f = nom + j; fl.push_back(f); nom = f;
      end else if (typ[i] == PCDBitSequence_X) begin
        f = nom + HALF + j; fl.push_back(f); nom = f - HALF;
      end
    end
    foreach (fl[i]) wl.push_back(int'($urandom_range(12, 1)));
  endfunction

  task automatic drive(input int fl[$], input int wl[$], input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      pause_n = 1'b1;
      foreach (fl[i]) if (edge_n + 1 >= fl[i] && edge_n + 1 < fl[i] + wl[i]) pause_n = 1'b0;
    end
    pause_n = 1'b1;
  endtask

  task automatic run(input int fl[$], input int wl[$], output int et[$], output PCDBitSequence ev[$],
                     output int ia);
    model(fl, et, ev, ia);
    got_t = {}; got_v = {}; idle_rise = -1; idle_fall = -1;
    drive(fl, wl, ((ia > edge_n) ? ia - edge_n : 3000) + 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pause_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (sd_seq !== PCDBitSequence_Y) begin n_fail++; $display("FAIL reset_seq: got %0d want %0d", sd_seq, PCDBitSequence_Y); end
    n_chk++; if (sd_seq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sd_seq_valid); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    rst_n = 1'b1;
    got_t = {}; got_v = {};
    repeat (300) @(posedge clk);
    #1;
    n_chk++; if (got_v.size() != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d strobes want 0", got_v.size()); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got %b want 1", idle); end
  endtask

  task automatic test_soc();
    int fl[$], wl[$], et[$], ia, t0;
    PCDBitSequence ev[$];
    PCDBitSequence want[3] = '{PCDBitSequence_Z, PCDBitSequence_Y, PCDBitSequence_Y};
    int wt[3];
    t0 = edge_n + 5;
    wt = '{t0 + 74, t0 + 202, t0 + 330};
    fl = '{t0}; wl = '{20};
    run(fl, wl, et, ev, ia);
    n_chk++; if (got_v.size() != 3) begin n_fail++; $display("FAIL soc_count: got %0d want 3", got_v.size()); end
    for (int i = 0; i < 3 && i < got_v.size(); i++) begin
      n_chk++;
      if (got_v[i] !== want[i] || got_t[i] !== wt[i]) begin
        n_fail++; $display("FAIL soc_strobe%0d: got seq %0d at t0+%0d want seq %0d at t0+%0d", i, got_v[i], got_t[i] - t0, want[i], wt[i] - t0);
      end
    end
    n_chk++; if (idle_fall !== t0 + 1) begin n_fail++; $display("FAIL soc_idle_fall: got t0+%0d want t0+1", idle_fall - t0); end
    n_chk++; if (idle_rise !== t0 + 331) begin n_fail++; $display("FAIL soc_idle_rise: got t0+%0d want t0+331", idle_rise - t0); end
  endtask

  // Byte 8'h29, parity 0, end of communication.
  task automatic test_stream(input string nm, input bit jit, input int mis, input int dbl);
    int fl[$], wl[$], et[$], ia, t0;
    PCDBitSequence ev[$], want[$];
    want = '{PCDBitSequence_Z, PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Z, PCDBitSequence_X,
             PCDBitSequence_Y, PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Z, PCDBitSequence_Z,
             PCDBitSequence_Z, PCDBitSequence_Y, PCDBitSequence_Y};
    t0 = edge_n + 5;
    gen(want, t0, jit, mis, 33, dbl, fl, wl);
    if (mis >= 0) want[mis] = PCDBitSequence_ERROR;
    if (dbl >= 0) want[dbl] = PCDBitSequence_ERROR;
    run(fl, wl, et, ev, ia);
    n_chk++; if (got_v.size() != want.size()) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", nm, got_v.size(), want.size()); end
    for (int i = 0; i < want.size() && i < got_v.size() && i < et.size(); i++) begin
      n_chk++;
      if (got_v[i] !== want[i] || got_t[i] !== et[i]) begin
        n_fail++; $display("FAIL %s_strobe%0d: got seq %0d at %0d want seq %0d at %0d", nm, i, got_v[i], got_t[i], want[i], et[i]);
      end
    end
    n_chk++; if (idle_rise !== ia || idle !== 1'b1) begin n_fail++; $display("FAIL %s_idle: got rise %0d idle %b want rise %0d idle 1", nm, idle_rise, idle, ia); end
  endtask

  task automatic test_reset_midframe();
    int fl[$], wl[$], et[$], ia, t0, t1, n_before;
    PCDBitSequence ev[$], typ[$];
    typ = '{PCDBitSequence_Z, PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Z, PCDBitSequence_X,
            PCDBitSequence_Y, PCDBitSequence_X, PCDBitSequence_Y, PCDBitSequence_Y};
    t0 = edge_n + 5;
    gen(typ, t0, 1'b0, -1, 0, -1, fl, wl);
    got_t = {}; got_v = {};
    drive(fl, wl, t0 + 5 * BT + 40 - edge_n);
    n_chk++; if (got_v.size() != 5 || sd_seq !== PCDBitSequence_X) begin n_fail++; $display("FAIL pre_reset: got %0d strobes seq %0d want 5 strobes seq %0d", got_v.size(), sd_seq, PCDBitSequence_X); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (sd_seq !== PCDBitSequence_Y || sd_seq_valid !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs: got seq %0d vld %b idle %b want seq %0d vld 0 idle 1", sd_seq, sd_seq_valid, idle, PCDBitSequence_Y);
    end
    n_before = got_v.size();
    repeat (200) @(posedge clk);
    #1;
    n_chk++; if (got_v.size() != n_before) begin n_fail++; $display("FAIL midreset_quiet: got %0d strobes want %0d", got_v.size(), n_before); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    t1 = edge_n + 5;
    fl = '{t1}; wl = '{3};
    run(fl, wl, et, ev, ia);
    n_chk++; if (got_v.size() == 0 || got_v[0] !== PCDBitSequence_Z || got_t[0] !== t1 + 74) begin
      n_fail++; $display("FAIL restart_first: got %0d strobes first seq %0d at t1+%0d want seq %0d at t1+74", got_v.size(), (got_v.size() > 0) ? got_v[0] : PCDBitSequence_Y, (got_t.size() > 0) ? got_t[0] - t1 : -1, PCDBitSequence_Z);
    end
    n_chk++; if (idle_rise !== ia) begin n_fail++; $display("FAIL restart_idle: got %0d want %0d", idle_rise, ia); end
  endtask

  task automatic test_random(input int iter);
    int fl[$], wl[$], et[$], ia, t0, n, mis;
    PCDBitSequence ev[$], typ[$], tp;
    typ = '{PCDBitSequence_Z};
    n = int'($urandom_range(16, 4));
    for (int i = 1; i <= n; i++) begin
      tp = PCDBitSequence'($urandom_range(2));
      if (tp == PCDBitSequence_Y && (typ[i-1] == PCDBitSequence_Y || i == n)) tp = PCDBitSequence_X;
      typ.push_back(tp);
    end
    typ.push_back(PCDBitSequence_Y); typ.push_back(PCDBitSequence_Y);
    mis = int'($urandom_range(n, 1));
    if (typ[mis] == PCDBitSequence_Y || $urandom_range(1) == 0) mis = -1;
    t0 = edge_n + 5;
    gen(typ, t0, 1'b1, mis, int'($urandom_range(40, 16)), -1, fl, wl);
    run(fl, wl, et, ev, ia);
    n_chk++; if (got_v.size() != ev.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", iter, got_v.size(), ev.size()); end
    for (int i = 0; i < ev.size() && i < got_v.size(); i++) begin
      n_chk++;
      if (got_v[i] !== ev[i] || got_t[i] !== et[i]) begin
        n_fail++; $display("FAIL rand%0d_strobe%0d: got seq %0d at %0d want seq %0d at %0d", iter, i, got_v[i], got_t[i], ev[i], et[i]);
      end
    end
    n_chk++; if (idle_rise !== ia) begin n_fail++; $display("FAIL rand%0d_idle: got %0d want %0d", iter, idle_rise, ia); end
  endtask

  initial begin
    test_reset();
    test_soc();
    test_stream("byte", 1'b0, -1, -1);
    test_stream("jitter", 1'b1, -1, -1);
    test_stream("misplaced", 1'b0, 3, -1);
    test_stream("double", 1'b0, -1, 3);
    test_reset_midframe();
    for (int k = 0; k < 4; k++) test_random(k);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
